// File: rtl/axi_lite_sram_slave.sv
// AXI4-lite SRAM responder with byte-strobe writes and a fixed or LFSR-driven
// response latency; one outstanding transaction, reads take priority over writes.
module axi_lite_sram_slave #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ACERR_WIDTH  = 2,
   parameter int                    WMASK_LENGTH = 4,
   parameter int                    DEPTH_LOG2   = 10,
   parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h8000_0000,
   parameter int                    RANDOM_DELAY = 1,
   parameter int                    FIXED_DELAY  = 0,
   parameter int                    DELAY_BITS   = 3
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [DATA_WIDTH-1:0]   araddr,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [ACERR_WIDTH-1:0]  rresp,
   output logic                    rvalid,
   input  logic                    rready,
   input  logic [DATA_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [WMASK_LENGTH-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [ACERR_WIDTH-1:0]  bresp,
   output logic                    bvalid,
   input  logic                    bready
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_R_DLY  = 3'd1;
   localparam logic [2:0] S_R_RESP = 3'd2;
   localparam logic [2:0] S_W_DLY  = 3'd3;
   localparam logic [2:0] S_W_RESP = 3'd4;

   localparam logic [DATA_WIDTH:0]    LIMIT    = {1'b0, BASE_ADDR} + ((DATA_WIDTH+1)'(1) << (DEPTH_LOG2 + 2));
   localparam logic [7:0]             DLY_MASK = 8'((1 << DELAY_BITS) - 1);
   localparam logic [7:0]             FIX_DLY  = 8'(FIXED_DELAY);
   localparam logic [ACERR_WIDTH-1:0] OKAY     = '0;
   localparam logic [ACERR_WIDTH-1:0] DECERR   = '1;

   logic [2:0]              state_q, state_d;
   logic [7:0]              cnt_q, cnt_d, lfsr_q, lfsr_d, dly;
   logic [DATA_WIDTH-1:0]   raddr_q, raddr_d, waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic [WMASK_LENGTH-1:0] wstrb_q, wstrb_d;
   logic                    aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic [ACERR_WIDTH-1:0]  rresp_q, rresp_d, bresp_q, bresp_d;
   logic                    ar_hs, aw_hs, w_hs, mem_we;
   logic [DATA_WIDTH-1:0]   mem [0:(2**DEPTH_LOG2)-1];

   function automatic logic in_range(input logic [DATA_WIDTH-1:0] a);
      return (a >= BASE_ADDR) && ({1'b0, a} < LIMIT);
   endfunction

   function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [DATA_WIDTH-1:0] a);
      logic [DATA_WIDTH-1:0] off;
      off = a - BASE_ADDR;
      return off[DEPTH_LOG2+1:2];
   endfunction

   assign arready = (state_q == S_IDLE);
   assign awready = (state_q == S_IDLE) && !aw_got_q;
   assign wready  = (state_q == S_IDLE) && !w_got_q;
   assign rvalid  = (state_q == S_R_RESP);
   assign bvalid  = (state_q == S_W_RESP);
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign bresp   = bresp_q;

   assign ar_hs  = arvalid && arready;
   assign aw_hs  = awvalid && awready;
   assign w_hs   = wvalid && wready;
   assign dly    = (RANDOM_DELAY != 0) ? (lfsr_q & DLY_MASK) : FIX_DLY;
   assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      raddr_d  = raddr_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      bresp_d  = bresp_q;
      mem_we   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (aw_hs) begin
               waddr_d  = awaddr;
               aw_got_d = 1'b1;
            end
            if (w_hs) begin
               wdata_d = wdata;
               wstrb_d = wstrb;
               w_got_d = 1'b1;
            end
            // A read wins; any write halves captured alongside it wait in aw_got/w_got.
            if (ar_hs) begin
               raddr_d = araddr;
               state_d = S_R_DLY;
               cnt_d   = dly;
            end else if (aw_got_d && w_got_d) begin
               state_d = S_W_DLY;
               cnt_d   = dly;
            end
         end
         S_R_DLY: begin
            if (cnt_q == 8'd0) begin
               state_d = S_R_RESP;
               rdata_d = in_range(raddr_q) ? mem[word_idx(raddr_q)] : '0;
               rresp_d = in_range(raddr_q) ? OKAY : DECERR;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_R_RESP: begin
            if (rready) begin
               if (aw_got_q && w_got_q) begin
                  state_d = S_W_DLY;
                  cnt_d   = dly;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_W_DLY: begin
            if (cnt_q == 8'd0) begin
               state_d  = S_W_RESP;
               bresp_d  = in_range(waddr_q) ? OKAY : DECERR;
               mem_we   = in_range(waddr_q);
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_W_RESP: begin
            if (bready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         lfsr_q   <= 8'hA5;
         aw_got_q <= 1'b0;
         w_got_q  <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= '0;
         bresp_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lfsr_q   <= lfsr_d;
         aw_got_q <= aw_got_d;
         w_got_q  <= w_got_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
         bresp_q  <= bresp_d;
      end
   end

   always_ff @(posedge clk) begin
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
   end

   // Gated by rstn so a write whose W_RESP entry coincides with reset is dropped.
   always_ff @(posedge clk) begin
      if (rstn && mem_we) begin
         for (int i = 0; i < WMASK_LENGTH; i++) begin
            if (wstrb_q[i]) mem[word_idx(waddr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench: u_fix (zero fixed latency) covers timing, strobes, decode and
// ordering; u_rnd (LFSR latency) covers backpressure and reset mid-write.
module tb_axi_lite_sram_slave;

   logic        clk = 1'b0;
   logic        rstn_f, rstn_r;
   logic [31:0] araddr, awaddr, wdata;
   logic        arvalid, rready, awvalid, wvalid, bready;
   logic [3:0]  wstrb;

   logic        arready_f, rvalid_f, awready_f, wready_f, bvalid_f;
   logic [31:0] rdata_f;
   logic [1:0]  rresp_f, bresp_f;
   logic        arready_r, rvalid_r, awready_r, wready_r, bvalid_r;
   logic [31:0] rdata_r;
   logic [1:0]  rresp_r, bresp_r;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_lite_sram_slave #(.RANDOM_DELAY(0), .FIXED_DELAY(0)) u_fix (
      .clk(clk), .rstn(rstn_f),
      .araddr(araddr), .arvalid(arvalid), .arready(arready_f),
      .rdata(rdata_f), .rresp(rresp_f), .rvalid(rvalid_f), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready_f),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_f),
      .bresp(bresp_f), .bvalid(bvalid_f), .bready(bready)
   );

   axi_lite_sram_slave #(.RANDOM_DELAY(1)) u_rnd (
      .clk(clk), .rstn(rstn_r),
      .araddr(araddr), .arvalid(arvalid), .arready(arready_r),
      .rdata(rdata_r), .rresp(rresp_r), .rvalid(rvalid_r), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready_r),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_r),
      .bresp(bresp_r), .bvalid(bvalid_r), .bready(bready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr_f(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [1:0] exp_resp, input string tag);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      chk({tag, "_awready"}, awready_f, 1);
      chk({tag, "_wready"}, wready_f, 1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk({tag, "_bvalid_early"}, bvalid_f, 0);
      tick();
      chk({tag, "_bvalid"}, bvalid_f, 1);
      chk({tag, "_bresp"}, bresp_f, exp_resp);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk({tag, "_bvalid_done"}, bvalid_f, 0);
   endtask

   task automatic rd_f(input logic [31:0] a, input logic [31:0] exp_data,
                       input logic [1:0] exp_resp, input string tag);
      araddr = a; arvalid = 1'b1;
      chk({tag, "_arready"}, arready_f, 1);
      tick();
      arvalid = 1'b0;
      chk({tag, "_rvalid_early"}, rvalid_f, 0);
      tick();
      chk({tag, "_rvalid"}, rvalid_f, 1);
      chk({tag, "_rdata"}, rdata_f, exp_data);
      chk({tag, "_rresp"}, rresp_f, exp_resp);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk({tag, "_rvalid_done"}, rvalid_f, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn_f = 1'b0; rstn_r = 1'b0;
      araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
      repeat (3) tick();
      chk("rst_arready", arready_f, 1);
      chk("rst_awready", awready_f, 1);
      chk("rst_wready", wready_f, 1);
      chk("rst_rvalid", rvalid_f, 0);
      chk("rst_bvalid", bvalid_f, 0);
      chk("rst_rdata", rdata_f, 0);
      chk("rst_rresp", rresp_f, 0);
      chk("rst_bresp", bresp_f, 0);
      rstn_f = 1'b1;
      tick();

      // Basic write then read, zero latency
      wr_f(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, "t1_wr");
      rd_f(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, "t1_rd");
      rd_f(32'h8000_0013, 32'hDEAD_BEEF, 2'b00, "t1_rd_lowbits");
      wr_f(32'h8000_0010, 32'h0000_0000, 4'h0, 2'b00, "t1_wr_nostrb");
      rd_f(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, "t1_rd_nostrb");

      // Byte strobes
      wr_f(32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, "t2_preset");
      wr_f(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00, "t2_wr");
      rd_f(32'h8000_0020, 32'h11BB_33DD, 2'b00, "t2_rd");

      // Address decode boundaries
      wr_f(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2'b00, "t3_preset");
      rd_f(32'h7FFF_FFFC, 32'h0000_0000, 2'b11, "t3_rd_below");
      wr_f(32'h8000_1000, 32'h1234_5678, 4'hF, 2'b11, "t3_wr_above");
      rd_f(32'h8000_0000, 32'hCAFE_F00D, 2'b00, "t3_rd_unchanged");
      wr_f(32'h8000_0FFC, 32'h0F0F_0F0F, 4'hF, 2'b00, "t3_wr_last");
      rd_f(32'h8000_0FFC, 32'h0F0F_0F0F, 2'b00, "t3_rd_last");
      rd_f(32'h8000_1000, 32'h0000_0000, 2'b11, "t3_rd_above");

      // AW three cycles ahead of W
      awaddr = 32'h8000_0030; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t4a_awready_low", awready_f, 0);
         chk("t4a_wready_high", wready_f, 1);
         chk("t4a_bvalid_idle", bvalid_f, 0);
         if (i < 2) tick();
      end
      wdata = 32'h0BAD_CAFE; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("t4a_bvalid_early", bvalid_f, 0);
      tick();
      chk("t4a_bvalid", bvalid_f, 1);
      chk("t4a_bresp", bresp_f, 2'b00);
      bready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4a_single_pulse", bvalid_f, 0);
      end
      bready = 1'b0;
      rd_f(32'h8000_0030, 32'h0BAD_CAFE, 2'b00, "t4a_rd");

      // W three cycles ahead of AW
      wdata = 32'h600D_D00D; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t4b_wready_low", wready_f, 0);
         chk("t4b_awready_high", awready_f, 1);
         chk("t4b_bvalid_idle", bvalid_f, 0);
         if (i < 2) tick();
      end
      awaddr = 32'h8000_0034; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("t4b_bvalid_early", bvalid_f, 0);
      tick();
      chk("t4b_bvalid", bvalid_f, 1);
      bready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4b_single_pulse", bvalid_f, 0);
      end
      bready = 1'b0;
      rd_f(32'h8000_0034, 32'h600D_D00D, 2'b00, "t4b_rd");

      // Simultaneous AR/AW/W: read first, returns old data
      wr_f(32'h8000_0040, 32'h0101_0101, 4'hF, 2'b00, "t5_preset");
      araddr = 32'h8000_0040; awaddr = 32'h8000_0040;
      wdata = 32'h0202_0202; wstrb = 4'hF;
      arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
      chk("t5_arready", arready_f, 1);
      chk("t5_awready", awready_f, 1);
      chk("t5_wready", wready_f, 1);
      tick();
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      chk("t5_arready_busy", arready_f, 0);
      chk("t5_awready_busy", awready_f, 0);
      chk("t5_wready_busy", wready_f, 0);
      chk("t5_rvalid_early", rvalid_f, 0);
      tick();
      chk("t5_rvalid", rvalid_f, 1);
      chk("t5_rdata_old", rdata_f, 32'h0101_0101);
      chk("t5_bvalid_during_read", bvalid_f, 0);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("t5_rvalid_done", rvalid_f, 0);
      chk("t5_bvalid_wdly", bvalid_f, 0);
      tick();
      chk("t5_bvalid", bvalid_f, 1);
      chk("t5_bresp", bresp_f, 2'b00);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("t5_bvalid_done", bvalid_f, 0);
      rd_f(32'h8000_0040, 32'h0202_0202, 2'b00, "t5_rd_new");

      // Random latency: backpressure and reset in W_DLY
      rstn_f = 1'b0;
      rstn_r = 1'b1;
      tick();
      chk("t6_rst_arready", arready_r, 1);
      chk("t6_rst_rvalid", rvalid_r, 0);
      chk("t6_rst_bvalid", bvalid_r, 0);
      chk("t6_rst_rdata", rdata_r, 0);
      awaddr = 32'h8000_0050; wdata = 32'h55AA_55AA; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("t6_wr_bvalid_early", bvalid_r, 0);
      for (int i = 0; i < 20 && !bvalid_r; i++) tick();
      chk("t6_wr_wait", bvalid_r, 1);
      chk("t6_wr_bresp", bresp_r, 2'b00);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("t6_wr_done", bvalid_r, 0);

      araddr = 32'h8000_0050; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      chk("t6_rd_rvalid_early", rvalid_r, 0);
      for (int i = 0; i < 20 && !rvalid_r; i++) tick();
      chk("t6_rd_wait", rvalid_r, 1);
      for (int i = 0; i < 5; i++) begin
         chk("t6_hold_rvalid", rvalid_r, 1);
         chk("t6_hold_rdata", rdata_r, 32'h55AA_55AA);
         chk("t6_hold_rresp", rresp_r, 2'b00);
         chk("t6_hold_arready", arready_r, 0);
         tick();
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("t6_rd_done", rvalid_r, 0);

      awaddr = 32'h8000_0050; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("t6_wdly_bvalid", bvalid_r, 0);
      chk("t6_wdly_awready", awready_r, 0);
      rstn_r = 1'b0;
      tick();
      rstn_r = 1'b1;
      chk("t6_post_rst_rvalid", rvalid_r, 0);
      chk("t6_post_rst_bvalid", bvalid_r, 0);
      chk("t6_post_rst_awready", awready_r, 1);
      chk("t6_post_rst_wready", wready_r, 1);
      tick();
      tick();
      chk("t6_no_stale_bvalid", bvalid_r, 0);
      araddr = 32'h8000_0050; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      for (int i = 0; i < 20 && !rvalid_r; i++) tick();
      chk("t6_rb_wait", rvalid_r, 1);
      chk("t6_rb_unchanged", rdata_r, 32'h55AA_55AA);
      rready = 1'b1;
      tick();
      rready = 1'b0;

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
